// File: rtl/stopwatch_pkg.sv
// Shared types for the stopwatch controller: FSM state encoding and a width helper.
// Used by stopwatch_ctrl and btn_debouncer.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUNNING = 2'd1,
    STOPPED = 2'd2
  } sw_state_t;

  // Bits needed to hold counts 0..n-1, never less than one.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/btn_debouncer.sv
// Button front end: 2-flop synchronizer, optional debounce filter, rising-edge strobe.
// Debounce filter is built only when STOPWATCH_DEBOUNCE_EN is defined.
module btn_debouncer
  import stopwatch_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic clk_i,
  input  logic res_ni,
  input  logic btn_i,
  output logic stb_o
);

  if (DEBOUNCE_CYCLES < 1) begin : g_bad_cfg
    $error("btn_debouncer: DEBOUNCE_CYCLES must be >= 1");
  end

  logic sync_q1;
  logic sync_q2;
  logic level;
  logic level_q;

  always_ff @(posedge clk_i or negedge res_ni) begin
    if (!res_ni) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
    end else begin
      sync_q1 <= btn_i;
      sync_q2 <= sync_q1;
    end
  end

`ifdef STOPWATCH_DEBOUNCE_EN
  localparam int unsigned DW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);

  logic [DW-1:0] db_cnt;
  logic          level_r;

  // Count consecutive cycles where the synchronized level disagrees with the
  // filtered one; any agreement (a bounce back) restarts the count.
  always_ff @(posedge clk_i or negedge res_ni) begin
    if (!res_ni) begin
      db_cnt  <= '0;
      level_r <= 1'b0;
    end else if (sync_q2 == level_r) begin
      db_cnt <= '0;
    end else if (db_cnt == DB_LAST) begin
      level_r <= sync_q2;
      db_cnt  <= '0;
    end else begin
      db_cnt <= db_cnt + 1'b1;
    end
  end

  assign level = level_r;
`else
  assign level = sync_q2;
`endif

  always_ff @(posedge clk_i or negedge res_ni) begin
    if (!res_ni) begin
      level_q <= 1'b0;
      stb_o   <= 1'b0;
    end else begin
      level_q <= level;
      stb_o   <= level & ~level_q;
    end
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: button-driven IDLE/RUNNING/STOPPED FSM, tick prescaler,
// counter-chain clear. Build with STOPWATCH_DEBOUNCE_EN to enable button debounce.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int unsigned CLK_DIV         = 1000,
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic       clk_i,
  input  logic       res_ni,
  input  logic       btn_i,
  output logic       tick_en_o,
  output logic       cnt_res_o,
  output logic [1:0] state_o,
  output logic       btn_stb_o
);

  if (CLK_DIV < 2) begin : g_bad_cfg
    $error("stopwatch_ctrl: CLK_DIV must be >= 2");
  end

  localparam int unsigned   PW       = $clog2(CLK_DIV);
  localparam logic [PW-1:0] PRE_LAST = PW'(CLK_DIV - 1);

  sw_state_t     state;
  sw_state_t     state_nxt;
  logic [PW-1:0] pre;
  logic [PW-1:0] pre_nxt;
  logic          cnt_res_nxt;
  logic          stb_raw;
  logic          press;

  btn_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn (
    .clk_i (clk_i),
    .res_ni(res_ni),
    .btn_i (btn_i),
    .stb_o (stb_raw)
  );

  // Presses are discarded while the counter chain is being cleared.
  assign press     = stb_raw & ~cnt_res_o;
  assign btn_stb_o = press;

  always_ff @(posedge clk_i or negedge res_ni) begin
    if (!res_ni) begin
      state     <= IDLE;
      pre       <= '0;
      cnt_res_o <= 1'b1;
    end else begin
      state     <= state_nxt;
      pre       <= pre_nxt;
      cnt_res_o <= cnt_res_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    pre_nxt     = pre;
    cnt_res_nxt = 1'b0;
    unique case (state)
      IDLE: begin
        pre_nxt = '0;
        if (press) state_nxt = RUNNING;
      end
      RUNNING: begin
        pre_nxt = (pre == PRE_LAST) ? '0 : pre + 1'b1;
        if (press) state_nxt = STOPPED;
      end
      STOPPED: begin
        // Prescaler stays frozen until the return to IDLE zeroes it.
        if (press) begin
          state_nxt   = IDLE;
          pre_nxt     = '0;
          cnt_res_nxt = 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        pre_nxt   = '0;
      end
    endcase
  end

  assign tick_en_o = (state == RUNNING) && (pre == PRE_LAST);
  assign state_o   = state;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed self-checking bench for stopwatch_ctrl (CLK_DIV=4, DEBOUNCE_CYCLES=3).
// Expected strobe latency follows STOPWATCH_DEBOUNCE_EN.
module tb_stopwatch_ctrl;

  localparam int unsigned DIV = 4;
  localparam int unsigned DEB = 3;
`ifdef STOPWATCH_DEBOUNCE_EN
  localparam int unsigned STB_EDGE  = DEB + 3;
  localparam int unsigned BOUNCE_STB = 1;
  localparam int unsigned BOUNCE_ST  = 1;
`else
  localparam int unsigned STB_EDGE  = 3;
  localparam int unsigned BOUNCE_STB = 3;
  localparam int unsigned BOUNCE_ST  = 0;
`endif

  logic       clk_i;
  logic       res_ni;
  logic       btn_i;
  logic       tick_en_o;
  logic       cnt_res_o;
  logic [1:0] state_o;
  logic       btn_stb_o;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned tick_cnt = 0;
  int unsigned stb_cnt = 0;
  int unsigned c3 = 0;

  stopwatch_ctrl #(
    .CLK_DIV(DIV),
    .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clk_i    (clk_i),
    .res_ni   (res_ni),
    .btn_i    (btn_i),
    .tick_en_o(tick_en_o),
    .cnt_res_o(cnt_res_o),
    .state_o  (state_o),
    .btn_stb_o(btn_stb_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Pulse counters plus a mod-3 first-stage timer_counter fed by the DUT outputs.
  always @(negedge clk_i) begin
    if (tick_en_o) tick_cnt++;
    if (btn_stb_o) stb_cnt++;
    if (cnt_res_o) c3 = 0;
    else if (tick_en_o) c3 = (c3 + 1) % 3;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Raises btn_i and walks to the strobe cycle, checking the strobe lands exactly there.
  task automatic press(input string tag);
    btn_i = 1'b1;
    for (int unsigned e = 1; e <= STB_EDGE; e++) begin
      step();
      if (e == STB_EDGE - 1) chk({tag, "_stb_early"}, btn_stb_o, 1'b0);
    end
    chk({tag, "_stb"}, btn_stb_o, 1'b1);
  endtask

  task automatic settle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) step();
  endtask

  initial begin
    int unsigned k;
    int unsigned snap_tick;
    int unsigned snap_stb;

    res_ni = 1'b0;
    btn_i  = 1'b0;

    // Reset state and release
    settle(2);
    chk("rst_cnt_res", cnt_res_o, 1'b1);
    chk("rst_state", state_o, 2'd0);
    chk("rst_tick", tick_en_o, 1'b0);
    chk("rst_stb", btn_stb_o, 1'b0);
    res_ni = 1'b1;
    #2;
    chk("rel_cnt_res_hold", cnt_res_o, 1'b1);
    step();
    chk("rel_cnt_res_clr", cnt_res_o, 1'b0);
    chk("rel_state", state_o, 2'd0);
    settle(4);
    chk("rel_no_tick", tick_cnt, 0);

    // Clean press: IDLE -> RUNNING, ticks every DIV cycles, button held
    press("clean");
    chk("clean_state_pre", state_o, 2'd0);
    step();
    chk("clean_state_run", state_o, 2'd1);
    chk("clean_stb_once", btn_stb_o, 1'b0);
    for (k = 1; k <= 12; k++) begin
      chk($sformatf("run_tick_c%0d", k), tick_en_o, (k % DIV) == 0);
      if (k == 1) chk("c3_k1", c3, 0);
      if (k == 5) chk("c3_k5", c3, 1);
      if (k == 9) chk("c3_k9", c3, 2);
      step();
    end
    chk("c3_k13", c3, 0);
    btn_i = 1'b0;
    settle(10);
    chk("clean_stb_total", stb_cnt, 1);
    chk("clean_still_run", state_o, 2'd1);

    // RUNNING -> STOPPED, no ticks while stopped
    press("stop");
    btn_i = 1'b0;
    step();
    chk("stop_state", state_o, 2'd2);
    snap_tick = tick_cnt;
    settle(8);
    chk("stop_no_tick", tick_cnt, snap_tick);
    chk("stop_state_hold", state_o, 2'd2);
    chk("stop_cnt_res", cnt_res_o, 1'b0);

    // STOPPED -> IDLE with a single-cycle clear
    press("clear");
    btn_i = 1'b0;
    step();
    chk("clear_state", state_o, 2'd0);
    chk("clear_cnt_res_on", cnt_res_o, 1'b1);
    step();
    chk("clear_cnt_res_off", cnt_res_o, 1'b0);
    chk("clear_c3", c3, 0);
    settle(10);

    // Coincident stop: strobe lands on the terminal prescaler cycle
    press("co_start");
    btn_i = 1'b0;
    step();
    k = 1;
    chk("co_run", state_o, 2'd1);
    while (!(k >= 8 && ((k + STB_EDGE) % DIV) == 0)) begin
      step();
      k++;
    end
    btn_i = 1'b1;
    for (int unsigned e = 1; e <= STB_EDGE; e++) begin
      step();
      k++;
    end
    chk("co_stb", btn_stb_o, 1'b1);
    chk("co_tick", tick_en_o, 1'b1);
    chk("co_state_run", state_o, 2'd1);
    btn_i = 1'b0;
    step();
    chk("co_state_stop", state_o, 2'd2);
    chk("co_tick_after", tick_en_o, 1'b0);
    settle(10);
    press("co_clear");
    btn_i = 1'b0;
    step();
    chk("co_clear_state", state_o, 2'd0);
    settle(10);

    // Bouncy press from IDLE: 1,0,1,0 then steady 1
    snap_stb = stb_cnt;
    btn_i = 1'b1; step();
    btn_i = 1'b0; step();
    btn_i = 1'b1; step();
    btn_i = 1'b0; step();
    btn_i = 1'b1;
    settle(14);
    chk("bounce_stb_count", stb_cnt - snap_stb, BOUNCE_STB);
    chk("bounce_state", state_o, BOUNCE_ST);

    // Mid-run reset aborts everything
    btn_i  = 1'b0;
    res_ni = 1'b0;
    #1;
    chk("abort_state", state_o, 2'd0);
    chk("abort_cnt_res", cnt_res_o, 1'b1);
    chk("abort_tick", tick_en_o, 1'b0);
    chk("abort_stb", btn_stb_o, 1'b0);
    settle(2);
    res_ni = 1'b1;
    snap_tick = tick_cnt;
    snap_stb  = stb_cnt;
    settle(12);
    chk("abort_no_tick", tick_cnt, snap_tick);
    chk("abort_no_stb", stb_cnt, snap_stb);
    chk("abort_idle", state_o, 2'd0);
    chk("abort_cnt_res_clr", cnt_res_o, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/stopwatch_ctrl.md
STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 SHALL have parameter CLK_DIV, default 1000, clk_i cycles per tick_en_o pulse (legal range >= 2).
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 16, consecutive stable cycles needed to accept a button level change (legal range >= 1).
REQ-003 SHALL have port clk_i  input  1  single system clock; all state changes on its rising edge.
REQ-004 SHALL have port res_ni  input  1  asynchronous active-low reset.
REQ-005 SHALL have port btn_i  input  1  raw asynchronous start/stop/clear button, active-high.
REQ-006 SHALL have port tick_en_o  output  1  one-cycle enable feeding en_i of the first timer_counter.
REQ-007 SHALL have port cnt_res_o  output  1  one-cycle clear feeding res_i of every timer_counter in the chain.
REQ-008 SHALL have port state_o  output  2  current state encoding (IDLE=0, RUNNING=1, STOPPED=2).
REQ-009 SHALL have port btn_stb_o  output  1  one-cycle accepted-press strobe.

Function
REQ-010 SHALL pass btn_i through a 2-flop synchronizer before any other use.
REQ-011 SHALL assert btn_stb_o for exactly one cycle per rising edge of the filtered button level; releases produce no strobe.
REQ-012 SHALL implement states IDLE, RUNNING and STOPPED, with transitions taken only at a clock edge where btn_stb_o=1: IDLE->RUNNING, RUNNING->STOPPED, STOPPED->IDLE.
REQ-013 SHALL hold a prescaler counter of width $clog2(CLK_DIV) that increments in RUNNING, wraps from CLK_DIV-1 to 0, freezes in STOPPED and is 0 in IDLE.
REQ-014 SHALL drive tick_en_o = (state==RUNNING) and (prescaler==CLK_DIV-1), so the first pulse falls in the CLK_DIV-th cycle of RUNNING and later pulses follow every CLK_DIV cycles.
REQ-015 SHALL continue from the frozen prescaler value on STOPPED->RUNNING, which is impossible by REQ-012 and is therefore never taken; resume requires IDLE, so each run starts at prescaler 0.
REQ-016 SHALL assert cnt_res_o (registered) for exactly the first cycle in which the state is IDLE after STOPPED.
REQ-017 SHALL still assert tick_en_o in a cycle where btn_stb_o and the terminal prescaler value coincide in RUNNING; the state goes to STOPPED on that edge.
REQ-018 SHALL ignore btn_i activity while cnt_res_o is high.

Reset
REQ-019 SHALL, while res_ni=0, force state to IDLE, prescaler to 0, synchronizer flops to 0, filtered level to 0, debounce counter to 0, tick_en_o to 0, btn_stb_o to 0 and cnt_res_o to 1.
REQ-020 SHALL clear cnt_res_o at the first rising clk_i edge after res_ni deasserts, so the counter chain is cleared at start-up.
REQ-021 SHALL treat a reset asserted mid-run as a full abort, with no residual tick or strobe afterwards.

Configuration
REQ-022 SHALL, with macro STOPWATCH_DEBOUNCE_EN defined, change the filtered level only after the synchronized level differs from it for DEBOUNCE_CYCLES consecutive cycles; any bounce resets the count. btn_stb_o is then high DEBOUNCE_CYCLES+3 edges after btn_i is first sampled high (clean press).
REQ-023 SHALL, without STOPWATCH_DEBOUNCE_EN, use the filtered level equal to the synchronized level, with btn_stb_o high after the 3rd edge at which btn_i is sampled high; DEBOUNCE_CYCLES is then unused.

Structure
REQ-024 SHALL place the state enum type (sw_state_t, 2-bit) and state encodings in shared package stopwatch_pkg.
REQ-025 SHALL implement synchronizer, debounce and edge detection in sub-module btn_debouncer (ports clk_i, res_ni, btn_i, stb_o).

Verification (CLK_DIV=4, DEBOUNCE_CYCLES=3, macro defined unless noted)
REQ-026 SHALL cover reset release: cnt_res_o=1 in reset and 0 one edge later; state_o=0; tick_en_o never 1.
REQ-027 SHALL cover a clean press: btn_stb_o pulses once at edge 6, state_o->1, tick_en_o pulses in RUNNING cycles 4, 8 and 12; with a chain of 3/4/5 timer_counters, DUT1 cnt reads 0,1,2,0.
REQ-028 SHALL cover a bouncy press (1,0,1,0 then steady 1): exactly one btn_stb_o, no strobe during the bounce.
REQ-029 SHALL cover the full cycle (press, press, press): state_o goes 1, 2, 0; tick_en_o stays 0 in STOPPED; cnt_res_o is high exactly one cycle on entry to IDLE.
REQ-030 SHALL cover a coincident stop, with btn_stb_o landing on the prescaler=3 cycle: tick_en_o=1 that cycle and state_o=2 next.
REQ-031 SHALL cover macro undefined: btn_stb_o at edge 3; bouncy input yields one strobe per synchronized rising edge.
